alu_pipe_arbiter: RTL

Round-robin arbiter that shares one 2-stage-registered 32-bit ALU pipeline among NREQ requesters. Each cycle it accepts at most one operation through a valid/ready handshake and drives the pipeline's operand and control inputs. It tracks the requester ID of every in-flight operation and returns each result tagged to its originator exactly PIPE_LAT cycles after issue. It sits between the operand-fetch clients and the ALU pipeline, and the pipeline instance connects directly to its abus/bbus/S/Cin/dbus ports.

---
 rtl/alu_pipe_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/alu_pipe_arbiter.sv
// Round-robin arbiter sharing one registered ALU pipeline among NREQ requesters.
// Tags every issued operation with its requester ID and returns it PIPE_LAT cycles later.
module alu_pipe_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned W        = 32,
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned IDW      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*3-1:0] req_s,
    input  logic [NREQ-1:0]   req_cin,
    output logic [W-1:0]      abus,
    output logic [W-1:0]      bbus,
    output logic [2:0]        S,
    output logic              Cin,
    input  logic [W-1:0]      dbus,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_data,
    output logic              busy
);

    localparam logic [IDW-1:0] LastId = IDW'(NREQ - 1);

    logic [IDW-1:0]          r_last;
    logic [PIPE_LAT-1:0]     r_tag_vld;
    logic [PIPE_LAT*IDW-1:0] r_tag_id;

    logic [NREQ-1:0] w_cand;
    logic            w_gnt_vld;
    logic [IDW-1:0]  w_gnt_id;
    logic [W-1:0]    w_a [NREQ];
    logic [W-1:0]    w_b [NREQ];
    logic [2:0]      w_s [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_a[i] = req_a[i*W +: W];
        assign w_b[i] = req_b[i*W +: W];
        assign w_s[i] = req_s[i*3 +: 3];
    end

    assign w_cand = (rst_n && en) ? req_valid : '0;

    // Walk from the requester after the last grant, wrapping at NREQ-1.
    always_comb begin : arb
        logic [IDW-1:0] idx;
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        idx       = r_last;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (idx == LastId) ? '0 : idx + IDW'(1);
            if (!w_gnt_vld && w_cand[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        abus      = '0;
        bbus      = '0;
        S         = '0;
        Cin       = 1'b0;
        if (w_gnt_vld) begin
            req_ready[w_gnt_id] = 1'b1;
            abus                = w_a[w_gnt_id];
            bbus                = w_b[w_gnt_id];
            S                   = w_s[w_gnt_id];
            Cin                 = req_cin[w_gnt_id];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last    <= LastId;
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            if (w_gnt_vld) begin
                r_last <= w_gnt_id;
            end
            // Stage 0 sits in the low bits; the oldest tag falls off the top.
            r_tag_vld <= PIPE_LAT'({r_tag_vld, w_gnt_vld});
            r_tag_id  <= (PIPE_LAT*IDW)'({r_tag_id, w_gnt_id});
        end
    end

    assign rsp_valid = r_tag_vld[PIPE_LAT-1];
    assign rsp_id    = r_tag_id[PIPE_LAT*IDW-1 -: IDW];
    assign rsp_data  = dbus;
    assign busy      = |r_tag_vld;

endmodule
